drop_sequencer: RTL and testbench

DROP_SEQUENCER -- requirements
Module: drop_sequencer

---
 rtl/drop_sequencer.sv | 149 ++++++++++++++
 tb/tb_drop_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drop_sequencer.sv
// -----------------------------------------------------------------------------
// drop_sequencer
//
// Purpose:
//   Sequences one passenger drop. On a request it waits for a sensor sample,
//   hands the latched sample and the current limit to the display/drop block
//   for one evaluation cycle, then either opens the drop door for DROP_CYCLES
//   cycles or holds the reject display for HOLD_CYCLES cycles. The verdict
//   comes only from drop_activated; this block never compares values itself.
//
// Ports:
//   clk            single clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   req            drop request, level sampled every cycle while idle
//   cfg_we         limit write strobe, only honoured while idle
//   cfg_lim        new limit (8.8 unsigned)
//   sens_valid     sensor sample valid
//   sens_data      sensor sample (8.8 unsigned)
//   sens_ready     high while waiting for a sample
//   drop_activated verdict from the display/drop block, sampled at end of EVAL
//   t_act          latched sample, held until the next accepted sample
//   t_lim          current limit
//   drop_en        evaluation/display enable (EVAL, DROP, REJECT)
//   door_open      drop door actuator (DROP only)
//   busy           high whenever the sequencer is not idle
//   err_timeout    one-cycle pulse when the sample wait expires
//   drop_count     accepted drops, saturating at 255
//   reject_count   rejected drops, saturating at 255
// -----------------------------------------------------------------------------
module drop_sequencer #(
  parameter int unsigned DROP_CYCLES = 50,
  parameter int unsigned HOLD_CYCLES = 20,
  parameter int unsigned TIMEOUT     = 100,
  parameter logic [15:0] LIM_RST     = 16'h1900
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        cfg_we,
  input  logic [15:0] cfg_lim,
  input  logic        sens_valid,
  input  logic [15:0] sens_data,
  output logic        sens_ready,
  input  logic        drop_activated,
  output logic [15:0] t_act,
  output logic [15:0] t_lim,
  output logic        drop_en,
  output logic        door_open,
  output logic        busy,
  output logic        err_timeout,
  output logic [7:0]  drop_count,
  output logic [7:0]  reject_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_EVAL   = 3'd2;
  localparam logic [2:0] S_DROP   = 3'd3;
  localparam logic [2:0] S_REJECT = 3'd4;

  // The timer counts from zero on state entry, so the last cycle of an
  // N-cycle state is the one where the timer reads N-1.
  localparam logic [15:0] DROP_LAST    = 16'(DROP_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [15:0] timer;

  // Every actuator and handshake output is a pure decode of the registered
  // state, so none of them can follow a glitch on an input.
  assign sens_ready = (state == S_WAIT);
  assign door_open  = (state == S_DROP);
  assign drop_en    = (state == S_EVAL) || (state == S_DROP) || (state == S_REJECT);
  assign busy       = (state != S_IDLE);

  // Main sequencer: state, cycle timer, latched sample, limit register and
  // the two saturating counters. Reset wins over every other input. In the
  // sample wait a handshake is checked before the timeout so that a sample
  // arriving on the very last allowed cycle is still accepted without an
  // error pulse. Counters bump on the EVAL exit edge, i.e. on entry to the
  // DROP or REJECT state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      t_act        <= '0;
      t_lim        <= LIM_RST;
      drop_count   <= '0;
      reject_count <= '0;
      err_timeout  <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_we) t_lim <= cfg_lim;
          if (req) begin
            state <= S_WAIT;
            timer <= '0;
          end
        end
        S_WAIT: begin
          if (sens_valid && sens_ready) begin
            t_act <= sens_data;
            state <= S_EVAL;
            timer <= '0;
          end else if (timer == TIMEOUT_LAST) begin
            state       <= S_IDLE;
            timer       <= '0;
            err_timeout <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_EVAL: begin
          timer <= '0;
          if (drop_activated) begin
            state <= S_DROP;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
          end else begin
            state <= S_REJECT;
            if (reject_count != 8'hFF) reject_count <= reject_count + 8'd1;
          end
        end
        S_DROP: begin
          if (timer == DROP_LAST) begin
            state <= S_IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_REJECT: begin
          if (timer == HOLD_LAST) begin
            state <= S_IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drop_sequencer.sv
// -----------------------------------------------------------------------------
// tb_drop_sequencer
//
// Purpose:
//   Self-checking bench for drop_sequencer with default parameters. A driver
//   task pushes the expected outcome of each drop sequence into a queue as
//   it drives the stimulus and pushes the observed outcome into a second
//   queue once the hold phase ends; each scenario task pops and compares.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_drop_sequencer;

  localparam int          DROP_CYCLES = 50;
  localparam int          HOLD_CYCLES = 20;
  localparam int          TIMEOUT     = 100;
  localparam logic [15:0] LIM_RST     = 16'h1900;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        cfg_we;
  logic [15:0] cfg_lim;
  logic        sens_valid;
  logic [15:0] sens_data;
  logic        sens_ready;
  logic        drop_activated;
  logic [15:0] t_act;
  logic [15:0] t_lim;
  logic        drop_en;
  logic        door_open;
  logic        busy;
  logic        err_timeout;
  logic [7:0]  drop_count;
  logic [7:0]  reject_count;

  int checks = 0;
  int errors = 0;

  // One record per drop sequence: hold length, door-open cycles, sample seen
  // in EVAL, counters after the hold, any error pulse, EVAL output pattern.
  typedef struct packed {
    logic [15:0] hold_len;
    logic [15:0] door_len;
    logic [15:0] act;
    logic [7:0]  dcnt;
    logic [7:0]  rcnt;
    logic        err_seen;
    logic        eval_ok;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  logic [7:0]  m_drop;
  logic [7:0]  m_rej;
  logic [15:0] m_lim;
  logic [15:0] m_act;

  drop_sequencer #(
    .DROP_CYCLES(DROP_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .TIMEOUT(TIMEOUT),
    .LIM_RST(LIM_RST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .cfg_we(cfg_we),
    .cfg_lim(cfg_lim),
    .sens_valid(sens_valid),
    .sens_data(sens_data),
    .sens_ready(sens_ready),
    .drop_activated(drop_activated),
    .t_act(t_act),
    .t_lim(t_lim),
    .drop_en(drop_en),
    .door_open(door_open),
    .busy(busy),
    .err_timeout(err_timeout),
    .drop_count(drop_count),
    .reject_count(reject_count)
  );

  always #5 clk = ~clk;

  // Hard stop in case a sequence never ends.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired before the test sequence ended");
    $fatal(1, "[TB] watchdog");
  end

  // Drives one full drop sequence from an IDLE negedge (or from the first
  // WAIT cycle when skip_start is set). Inputs change on negedges only.
  task automatic run_sequence(input logic [15:0] sample, input logic verdict,
                              input int delay, input logic keep_req,
                              input logic skip_start, input logic hold_cfg,
                              input logic noise, input int rst_at);
    rec_t e;
    rec_t o;
    int   n;
    o = '0;
    e = '0;
    if (!skip_start) begin
      req = 1'b1;
      @(negedge clk);
      if (!keep_req) req = 1'b0;
    end
    for (int i = 0; i < delay; i++) begin
      if (err_timeout === 1'b1) o.err_seen = 1'b1;
      @(negedge clk);
    end
    if (err_timeout === 1'b1) o.err_seen = 1'b1;
    sens_valid = 1'b1;
    sens_data  = sample;
    @(negedge clk);
    sens_valid = 1'b0;
    if (err_timeout === 1'b1) o.err_seen = 1'b1;
    o.eval_ok = (drop_en === 1'b1) && (door_open === 1'b0) &&
                (sens_ready === 1'b0) && (busy === 1'b1);
    o.act = t_act;

    e.act      = sample;
    m_act      = sample;
    e.eval_ok  = 1'b1;
    e.hold_len = (rst_at > 0) ? 16'(rst_at) :
                 (verdict ? 16'(DROP_CYCLES) : 16'(HOLD_CYCLES));
    e.door_len = verdict ? e.hold_len : 16'd0;
    if (verdict && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
    if (!verdict && m_rej != 8'hFF) m_rej = m_rej + 8'd1;
    if (rst_at > 0) begin
      m_drop = '0;
      m_rej  = '0;
      m_lim  = LIM_RST;
      m_act  = '0;
    end
    e.dcnt = m_drop;
    e.rcnt = m_rej;
    exp_q.push_back(e);

    drop_activated = verdict;
    @(negedge clk);
    drop_activated = 1'b0;
    n = 0;
    while (drop_en === 1'b1 && n < 1000) begin
      if (door_open === 1'b1) o.door_len = o.door_len + 16'd1;
      n++;
      if (hold_cfg && n == 5) begin
        cfg_we  = 1'b1;
        cfg_lim = 16'h1E00;
      end else begin
        cfg_we = 1'b0;
      end
      if (noise) begin
        sens_valid = 1'b1;
        sens_data  = 16'hDEAD;
      end
      if (rst_at > 0 && n == rst_at) rst = 1'b1;
      @(negedge clk);
    end
    cfg_we   = 1'b0;
    rst      = 1'b0;
    o.hold_len = 16'(n);
    o.dcnt     = drop_count;
    o.rcnt     = reject_count;
    obs_q.push_back(o);
  endtask

  // Reset with every other input active: reset must win and clear all state.
  task automatic test_reset();
    rst = 1'b1; req = 1'b1; cfg_we = 1'b1; cfg_lim = 16'h1234;
    sens_valid = 1'b1; sens_data = 16'hBEEF; drop_activated = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (drop_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_drop_en got %b want 0", drop_en); end
    checks++; if (door_open !== 1'b0) begin errors++; $display("[TB] FAIL reset_door got %b want 0", door_open); end
    checks++; if (sens_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", sens_ready); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err_timeout); end
    checks++; if (t_act !== 16'h0000) begin errors++; $display("[TB] FAIL reset_t_act got %h want 0000", t_act); end
    checks++; if (t_lim !== LIM_RST) begin errors++; $display("[TB] FAIL reset_t_lim got %h want %h", t_lim, LIM_RST); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop_count got %0d want 0", drop_count); end
    checks++; if (reject_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_reject_count got %0d want 0", reject_count); end
    rst = 1'b0; req = 1'b0; cfg_we = 1'b0; sens_valid = 1'b0; drop_activated = 1'b0;
    m_drop = '0; m_rej = '0; m_lim = LIM_RST; m_act = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || t_lim !== m_lim) begin errors++; $display("[TB] FAIL post_reset_idle got busy=%b lim=%h want busy=0 lim=%h", busy, t_lim, m_lim); end
  endtask

  // Accepted drop: 23.5 against a 25.0 limit with a positive verdict.
  task automatic test_accept();
    rec_t e;
    rec_t o;
    run_sequence(16'h1780, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    checks++; if (o !== e) begin errors++; $display("[TB] FAIL accept_seq got %h want %h", o, e); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL accept_idle got busy=%b want 0", busy); end
  endtask

  // Reject path with the sample equal to the limit; sens_valid is kept high
  // through the hold and one idle cycle and must be ignored there.
  task automatic test_reject();
    rec_t e;
    rec_t o;
    run_sequence(16'h1900, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    @(negedge clk);
    sens_valid = 1'b0;
    e = exp_q.pop_front(); o = obs_q.pop_front();
    checks++; if (o !== e) begin errors++; $display("[TB] FAIL reject_seq got %h want %h", o, e); end
    checks++; if (busy !== 1'b0 || t_act !== m_act) begin errors++; $display("[TB] FAIL reject_ignore_valid got busy=%b act=%h want busy=0 act=%h", busy, t_act, m_act); end
  endtask

  // Sample wait expiry, then a sample arriving on the boundary cycle.
  task automatic test_timeout();
    rec_t e;
    rec_t o;
    int   n;
    int   pulses;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    n = 0;
    pulses = 0;
    while (sens_ready === 1'b1 && n < 300) begin
      n++;
      if (err_timeout === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++; if (n != TIMEOUT) begin errors++; $display("[TB] FAIL timeout_wait_len got %0d want %0d", n, TIMEOUT); end
    checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL timeout_early_pulse got %0d want 0", pulses); end
    checks++; if (err_timeout !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_pulse got err=%b busy=%b want err=1 busy=0", err_timeout, busy); end
    checks++; if (t_act !== m_act) begin errors++; $display("[TB] FAIL timeout_t_act got %h want %h", t_act, m_act); end
    @(negedge clk);
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_pulse_width got %b want 0", err_timeout); end
    run_sequence(16'h1A80, 1'b1, TIMEOUT - 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    checks++; if (o !== e) begin errors++; $display("[TB] FAIL timeout_boundary_seq got %h want %h", o, e); end
  endtask

  // Limit writes are ignored mid-drop, honoured in idle, and combine with req.
  task automatic test_config();
    rec_t e;
    rec_t o;
    run_sequence(16'h1800, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    checks++; if (o !== e) begin errors++; $display("[TB] FAIL cfg_drop_seq got %h want %h", o, e); end
    checks++; if (t_lim !== m_lim) begin errors++; $display("[TB] FAIL cfg_gated_in_drop got %h want %h", t_lim, m_lim); end
    cfg_we = 1'b1; cfg_lim = 16'h1E00;
    @(negedge clk);
    cfg_we = 1'b0; m_lim = 16'h1E00;
    checks++; if (t_lim !== m_lim || busy !== 1'b0) begin errors++; $display("[TB] FAIL cfg_idle_write got lim=%h busy=%b want lim=%h busy=0", t_lim, busy, m_lim); end
    req = 1'b1; cfg_we = 1'b1; cfg_lim = 16'h1900;
    @(negedge clk);
    req = 1'b0; cfg_we = 1'b0; m_lim = 16'h1900;
    checks++; if (t_lim !== m_lim || sens_ready !== 1'b1) begin errors++; $display("[TB] FAIL cfg_with_req got lim=%h ready=%b want lim=%h ready=1", t_lim, sens_ready, m_lim); end
    run_sequence(16'h1900, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    checks++; if (o !== e) begin errors++; $display("[TB] FAIL cfg_req_seq got %h want %h", o, e); end
  endtask

  // Held req: ignored while busy, restarts after exactly one idle cycle.
  task automatic test_back_to_back();
    rec_t e;
    rec_t o;
    run_sequence(16'h1700, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_gap got busy=%b want 0", busy); end
    @(negedge clk);
    req = 1'b0;
    checks++; if (sens_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart got ready=%b want 1", sens_ready); end
    run_sequence(16'h1880, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    checks++; if (o !== e) begin errors++; $display("[TB] FAIL b2b_first_seq got %h want %h", o, e); end
    e = exp_q.pop_front(); o = obs_q.pop_front();
    checks++; if (o !== e) begin errors++; $display("[TB] FAIL b2b_second_seq got %h want %h", o, e); end
  endtask

  // 256 accepted drops saturate the counter; then reset on DROP cycle 10.
  task automatic test_saturation();
    rec_t e;
    rec_t o;
    for (int i = 0; i < 256; i++) begin
      run_sequence(16'h1000 + 16'(i), 1'b1, i % 3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL sat_seq_%0d got %h want %h", i, o, e); end
    end
    checks++; if (drop_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_drop_count got %0d want 255", drop_count); end
    run_sequence(16'h1780, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    checks++; if (o !== e) begin errors++; $display("[TB] FAIL rst_mid_drop_seq got %h want %h", o, e); end
    checks++; if (door_open !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_drop_door got door=%b busy=%b want 0 0", door_open, busy); end
    checks++; if (t_act !== m_act || t_lim !== m_lim) begin errors++; $display("[TB] FAIL rst_mid_drop_regs got act=%h lim=%h want act=%h lim=%h", t_act, t_lim, m_act, m_lim); end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; cfg_we = 1'b0; cfg_lim = '0;
    sens_valid = 1'b0; sens_data = '0; drop_activated = 1'b0;
    m_drop = '0; m_rej = '0; m_lim = LIM_RST; m_act = '0;
    $display("[TB] drop_sequencer bench start");
    test_reset();
    test_accept();
    test_reject();
    test_timeout();
    test_config();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
